// File: rtl/dff_pipe_if.sv
// dff_pipe_if: handshake/data bundle for dff_pipe
// Ports: en_n, flush, in_valid, d (producer -> pipe); q, out_valid, count, stall_cnt (pipe -> consumer).
// master = producer side, slave = the pipe itself.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             en_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic [15:0]      stall_cnt;
  modport master (output en_n, flush, in_valid, d, input q, out_valid, count, stall_cnt);
  modport slave (input en_n, flush, in_valid, d, output q, out_valid, count, stall_cnt);
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH register pipeline with per-stage valid, active-low advance, flush and occupancy count
// Ports: clk, rst (async active-high), bus (dff_pipe_if.slave: en_n, flush, in_valid, d -> q, out_valid, count, stall_cnt).
// Optional macro DFF_PIPE_STALL_CNT_EN adds a saturating held-item stall counter; otherwise stall_cnt is 0.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               CLK_NEG = 1'b1
) (
  input logic       clk,
  input logic       rst,
  dff_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic                        eclk;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d;
  // CLK_NEG is static, so this resolves to a plain wire or a single clock inverter
  assign eclk = CLK_NEG ? ~clk : clk;
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (bus.flush) begin
      data_d  = {DEPTH{RST_VAL}};
      valid_d = '0;
      count_d = '0;
    end else if (!bus.en_n) begin
      data_d[0]  = bus.d;
      valid_d[0] = bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // occupancy tracks items entering minus the one leaving the last stage
      count_d = count_q + CW'(bus.in_valid) - CW'(valid_q[DEPTH-1]);
    end
  end
  always_ff @(posedge eclk or posedge rst) begin
    if (rst) begin
      data_q  <= {DEPTH{RST_VAL}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end
  assign bus.q         = data_q[DEPTH-1];
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.count     = count_q;
`ifdef DFF_PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  // counts edges where a valid item sits in a held pipe, saturating at all-ones
  assign stall_d = bus.flush ? '0
                 : (bus.en_n && count_q != '0 && stall_q != 16'hFFFF) ? stall_q + 16'd1
                 : stall_q;
  always_ff @(posedge eclk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed + randomized bench for dff_pipe against an array-based reference model
module tb_dff_pipe;
  localparam int D = 4;
  localparam logic [7:0] RV = 8'hA5;
`ifdef DFF_PIPE_STALL_CNT_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int fails = 0;
  logic [7:0] md[D];
  logic       mv[D];
  int         ms;
  dff_pipe_if #(.WIDTH(8), .DEPTH(D)) bn();
  dff_pipe_if #(.WIDTH(8), .DEPTH(2)) bp();
  dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV), .CLK_NEG(1'b1)) dut (.clk(clk), .rst(rst), .bus(bn));
  dff_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00), .CLK_NEG(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(bp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(mv[i]);
    return c;
  endfunction
  task automatic mreset();
    for (int i = 0; i < D; i++) begin
      md[i] = RV;
      mv[i] = 1'b0;
    end
    ms = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(bn.q), 32'(md[D-1]));
    chk({tag, ".out_valid"}, 32'(bn.out_valid), 32'(mv[D-1]));
    chk({tag, ".count"}, 32'(bn.count), 32'(mcount()));
    chk({tag, ".stall_cnt"}, 32'(bn.stall_cnt), STALL ? 32'(ms) : 32'd0);
  endtask
  task automatic step(input bit en_n, input bit fl, input bit iv, input logic [7:0] dd, input bit c = 1'b1);
    @(posedge clk);
    #1;
    if (c) check_all("posedge_quiet");
    bn.en_n = en_n;
    bn.flush = fl;
    bn.in_valid = iv;
    bn.d = dd;
    @(negedge clk);
    if (fl) begin
      for (int i = 0; i < D; i++) begin
        md[i] = RV;
        mv[i] = 1'b0;
      end
      ms = 0;
    end else if (!en_n) begin
      for (int i = D - 1; i > 0; i--) begin
        md[i] = md[i-1];
        mv[i] = mv[i-1];
      end
      md[0] = dd;
      mv[0] = iv;
    end else if (mcount() != 0 && ms < 65535) begin
      ms++;
    end
    #1;
    if (c) check_all("negedge");
  endtask
  initial begin
    logic [7:0] lat[5];
    lat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bn.en_n = 1'b1; bn.flush = 1'b0; bn.in_valid = 1'b0; bn.d = '0;
    bp.en_n = 1'b1; bp.flush = 1'b0; bp.in_valid = 1'b0; bp.d = '0;
    #1 rst = 1'b1;
    #1 mreset();
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, lat[i]);
      if (i == 3) chk("latency.q11", 32'(bn.q), 32'h11);
    end
    step(1'b0, 1'b0, 1'b1, 8'h61);
    step(1'b0, 1'b0, 1'b0, 8'h62);
    step(1'b0, 1'b0, 1'b1, 8'h63);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hA1);
    step(1'b0, 1'b0, 1'b1, 8'hA2);
    step(1'b0, 1'b0, 1'b1, 8'hA3);
    chk("pre_flush.count", 32'(bn.count), 32'd3);
    step(1'b0, 1'b1, 1'b1, 8'h77);
    chk("flush.q", 32'(bn.q), 32'(RV));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("flush.no77", 32'(bn.q == 8'h77), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 8'hB1);
    step(1'b0, 1'b0, 1'b1, 8'hB2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall5", 32'(bn.stall_cnt), STALL ? 32'd5 : 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("stall_flush", 32'(bn.stall_cnt), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'hC1);
    for (int i = 0; i < 65600; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_all("saturate");
    chk("stall_sat", 32'(bn.stall_cnt), STALL ? 32'hFFFF : 32'd0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i));
    #1 rst = 1'b1;
    #1 mreset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 8'hE7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_rst.latency", 32'(bn.q), 32'hE7);
    @(negedge clk);
    #1;
    bp.en_n = 1'b0; bp.in_valid = 1'b1; bp.d = 8'h3C;
    @(posedge clk);
    #1;
    chk("rise.count1", 32'(bp.count), 32'd1);
    chk("rise.q_rst", 32'(bp.q), 32'h00);
    bp.in_valid = 1'b0; bp.d = 8'hC3;
    @(negedge clk);
    #1;
    chk("rise.neg_quiet.count", 32'(bp.count), 32'd1);
    chk("rise.neg_quiet.ov", 32'(bp.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rise.q", 32'(bp.q), 32'h3C);
    chk("rise.ov", 32'(bp.out_valid), 32'd1);
    chk("rise.count2", 32'(bp.count), 32'd1);
    bp.en_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rise.hold.q", 32'(bp.q), 32'h3C);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
